clk_period_meter: RTL and testbench
===================================

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the measurement counter and its results.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on clk_in; the minimum legal value is 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-006 Port clk_in, input, 1 bit: divided clock to be measured; it is asynchronous to clk.
REQ-007 Port start, input, 1 bit: single-cycle request to begin one measurement.
REQ-008 Port ack, input, 1 bit: consumer acknowledge of a valid result.
REQ-009 Port period, output, CNT_W bits: clk cycles between two consecutive rising edges of clk_in.
REQ-010 Port high_time, output, CNT_W bits: clk cycles from a clk_in rising edge to the next falling edge.
REQ-011 Port valid, output, 1 bit: period and high_time hold a new result.
REQ-012 Port busy, output, 1 bit: a measurement is in progress.
REQ-013 Port timeout, output, 1 bit: single-cycle pulse when a measurement is aborted.

Function
REQ-014 clk_in SHALL pass through SYNC_STAGES flops and then a one-flop edge detector, producing rise and fall strobes.
- Each strobe is one cycle wide.
- Each strobe appears SYNC_STAGES+1 cycles after the clk_in edge.
REQ-015 The FSM SHALL have four states: IDLE, ARM, MEASURE and DONE.
REQ-016 IDLE: on start, the FSM SHALL go to ARM, clear the counter to 0 and clear high_time to 0.
REQ-017 ARM: the counter SHALL increment each cycle; on rise, the counter SHALL load 1 and the FSM SHALL go to MEASURE.
REQ-018 MEASURE: with no rise, the counter SHALL increment each cycle.
- On the first fall, high_time SHALL load the counter value.
- On rise, period SHALL load the counter value, valid SHALL be set and the FSM SHALL go to DONE.
REQ-019 DONE: valid, period and high_time SHALL hold until ack; on ack, valid SHALL clear the next cycle and the FSM SHALL go to IDLE.
REQ-020 If ack and start are both high in DONE, the FSM SHALL go directly to ARM and valid SHALL clear.
REQ-021 start SHALL be ignored in ARM and MEASURE, and in DONE when ack is low.
REQ-022 ack SHALL be ignored outside DONE.
REQ-023 Timeout: in ARM or MEASURE, if the counter equals all-ones and no rise is present, the block SHALL do the following:
- pulse timeout for one cycle;
- go to IDLE;
- leave period unchanged and valid low.
REQ-024 The counter SHALL never wrap; saturation always causes the timeout of REQ-023.
REQ-025 If no fall occurs in MEASURE, high_time SHALL report 0.
REQ-026 busy SHALL be high exactly in ARM and MEASURE.
REQ-027 The minimum measurable period SHALL be 2 clk cycles; behaviour for faster clk_in is undefined.

Reset
REQ-028 While reset is low, the block SHALL do the following:
- go to IDLE;
- clear the counter, period, high_time, valid, busy and timeout to 0;
- clear all synchronizer and edge flops to 0.
REQ-029 Reset asserted mid-measurement SHALL abort with no timeout pulse and no valid.
REQ-030 The first clk_in rise after reset release SHALL be detected only when the FSM is in ARM.

Structure
REQ-031 A shared package clk_meas_pkg SHALL hold the following:
- the FSM state enum (IDLE, ARM, MEASURE, DONE);
- the default CNT_W constant;
- the default SYNC_STAGES constant.
REQ-032 Sub-module sync_edge_det SHALL contain the synchronizer and the edge detector and output rise and fall; the FSM and the counter live in the top module.

Verification
REQ-033 clk_in equals clk/4 (2 high, 2 low); start pulse -> valid with period=4 and high_time=2; valid holds until ack.
REQ-034 clk_in with a 10-cycle period and 3 high cycles, at a random phase -> period=10, high_time=3; start issued while busy has no effect.
REQ-035 clk_in held low, CNT_W=8, start -> timeout pulses once after 256 ARM cycles; busy then drops and valid stays low.
REQ-036 In DONE, ack and start in the same cycle -> valid low the next cycle, busy high, and a second result of period=4 for clk/4.
REQ-037 Reset asserted during MEASURE -> all outputs are 0 the next cycle; the next start after release measures correctly.

Source files
------------

// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clk_in period/high-time meter.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } meas_state_t;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Brings the asynchronous clk_in into the clk domain and emits one-cycle
// rise/fall strobes from the synchronized level.
module sync_edge_det
  import clk_meas_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], clk_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign fall = ~sync_reg[SYNC_STAGES-1] & prev_reg;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of clk_in in clk cycles, one measurement per
// start request, with a saturating counter that aborts via a timeout pulse.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             start,
  input  logic             ack,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             busy,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic rise;
  logic fall;

  meas_state_t      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] high_time_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             timeout_reg;
  logic             fall_seen_reg;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk    (clk),
    .reset  (reset),
    .clk_in (clk_in),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      period_reg    <= '0;
      high_time_reg <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      fall_seen_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= ARM;
            cnt_reg       <= '0;
            high_time_reg <= '0;
            fall_seen_reg <= 1'b0;
            busy_reg      <= 1'b1;
          end
        end
        ARM: begin
          // Counting from start lets a clk_in that never toggles still time out.
          if (rise) begin
            cnt_reg   <= CNT_ONE;
            state_reg <= MEASURE;
          end else if (cnt_reg == CNT_MAX) begin
            timeout_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_reg <= cnt_reg;
            valid_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= DONE;
          end else if (cnt_reg == CNT_MAX) begin
            timeout_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
            if (fall && !fall_seen_reg) begin
              high_time_reg <= cnt_reg;
              fall_seen_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ack) begin
            valid_reg <= 1'b0;
            if (start) begin
              state_reg     <= ARM;
              cnt_reg       <= '0;
              high_time_reg <= '0;
              fall_seen_reg <= 1'b0;
              busy_reg      <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign period    = period_reg;
  assign high_time = high_time_reg;
  assign valid     = valid_reg;
  assign busy      = busy_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed scoreboard bench for clk_period_meter (CNT_W=8).
module tb_clk_period_meter;

  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             clk_in;
  logic             start;
  logic             ack;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             busy;
  logic             timeout;

  clk_period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_in    (clk_in),
    .start     (start),
    .ack       (ack),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  typedef struct {
    bit       is_timeout;
    int       exp_period;
    int       exp_high;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // clk_in pattern controls, written only by the stimulus process
  int gen_p   = 0;
  int gen_h   = 0;
  int gen_off = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int cyc;
    cyc    = 0;
    clk_in = 1'b0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (gen_p == 0) clk_in = 1'b0;
      else            clk_in = (((cyc + gen_off) % gen_p) < gen_h);
    end
  end

  function automatic void chk(string name, int act, int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: compare every new result or timeout pulse against the scoreboard
  initial begin
    logic valid_q;
    exp_t e;
    valid_q = 1'b0;
    forever begin
      @(negedge clk);
      if ((valid && !valid_q) || timeout) begin
        if (sb.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL sb_unexpected: got valid=%0d timeout=%0d period=%0d expected no output",
                   valid, timeout, period);
        end else begin
          e = sb.pop_front();
          chk("sb_kind_timeout", int'(timeout), int'(e.is_timeout));
          if (!e.is_timeout) begin
            chk("sb_period", int'(period), e.exp_period);
            chk("sb_high_time", int'(high_time), e.exp_high);
            $display("result: period=%0d high_time=%0d", period, high_time);
          end else begin
            chk("sb_valid_on_timeout", int'(valid), 0);
            $display("timeout observed");
          end
        end
      end
      valid_q = valid;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!valid && n < budget) begin
      @(negedge clk);
      n = n + 1;
    end
    chk(name, int'(valid), 1);
  endtask

  task automatic set_gen(input int p, input int h, input int off);
    gen_p   = p;
    gen_h   = h;
    gen_off = off;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   n;
    reset = 1'b0;
    start = 1'b0;
    ack   = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_period", int'(period), 0);
    chk("rst_high_time", int'(high_time), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout", int'(timeout), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // clk/4, 2 high 2 low
    set_gen(4, 2, 0);
    e = '{is_timeout: 1'b0, exp_period: 4, exp_high: 2};
    sb.push_back(e);
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    wait_valid("t1_valid_wait", 100);
    repeat (5) @(negedge clk);
    chk("t1_valid_hold", int'(valid), 1);
    chk("t1_period_hold", int'(period), 4);
    chk("t1_busy_done", int'(busy), 0);
    pulse_ack();
    chk("t1_valid_after_ack", int'(valid), 0);
    chk("t1_busy_after_ack", int'(busy), 0);

    // 10-cycle period, 3 high, random phase; extra start while busy
    set_gen(10, 3, $urandom_range(0, 9));
    e = '{is_timeout: 1'b0, exp_period: 10, exp_high: 3};
    sb.push_back(e);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("t2_busy", int'(busy), 1);
    pulse_start();
    wait_valid("t2_valid_wait", 100);
    pulse_ack();
    repeat (3) @(negedge clk);
    chk("t2_busy_idle", int'(busy), 0);
    chk("t2_valid_idle", int'(valid), 0);

    // clk_in stuck low: timeout after 256 ARM cycles
    set_gen(0, 0, 0);
    e = '{is_timeout: 1'b1, exp_period: 0, exp_high: 0};
    sb.push_back(e);
    pulse_start();
    n = 0;
    while (!timeout && n < 400) begin
      @(negedge clk);
      n = n + 1;
    end
    chk("t3_timeout_latency", n, 256);
    chk("t3_busy_at_timeout", int'(busy), 0);
    @(negedge clk);
    chk("t3_timeout_single", int'(timeout), 0);
    chk("t3_busy_after", int'(busy), 0);
    chk("t3_valid_after", int'(valid), 0);
    chk("t3_period_kept", int'(period), 10);

    // ack together with start in DONE
    set_gen(4, 2, 1);
    e = '{is_timeout: 1'b0, exp_period: 4, exp_high: 2};
    sb.push_back(e);
    pulse_start();
    wait_valid("t4_valid_wait1", 100);
    sb.push_back(e);
    @(negedge clk);
    ack   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
    chk("t4_valid_cleared", int'(valid), 0);
    chk("t4_busy_rearmed", int'(busy), 1);
    wait_valid("t4_valid_wait2", 100);
    pulse_ack();

    // Reset in the middle of a long measurement
    set_gen(20, 5, 0);
    pulse_start();
    repeat (20) @(negedge clk);
    chk("t5_busy_before_rst", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("t5_rst_period", int'(period), 0);
    chk("t5_rst_high_time", int'(high_time), 0);
    chk("t5_rst_valid", int'(valid), 0);
    chk("t5_rst_busy", int'(busy), 0);
    @(negedge clk);
    chk("t5_rst_timeout", int'(timeout), 0);
    reset = 1'b1;
    set_gen(4, 2, 2);
    e = '{is_timeout: 1'b0, exp_period: 4, exp_high: 2};
    sb.push_back(e);
    pulse_start();
    wait_valid("t5_valid_wait", 100);
    pulse_ack();
    repeat (5) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
